// File: rtl/forwarding_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package forwarding_pkg;

  localparam int unsigned REG_AW = 5;

  // Parameter defaults for forwarding_scoreboard
  localparam int unsigned NUM_SRC_DEFAULT          = 2;
  localparam int unsigned DEPTH_DEFAULT            = 3;
  localparam int unsigned LOAD_READY_STAGE_DEFAULT = 2;

  // fwd_sel value meaning "read the register file"
  localparam int unsigned FWD_NONE = 0;

  // Destination tag of one in-flight post-EX instruction
  typedef struct packed {
    logic              valid;
    logic              regwrite;
    logic              is_load;
    logic [REG_AW-1:0] rd;
  } fwd_entry_t;

endpackage

// File: rtl/fwd_match.sv
// Per-source priority matcher: finds the youngest in-flight producer of one
// source register and reports whether its data is forwardable yet.
module fwd_match
  import forwarding_pkg::*;
#(
  parameter int unsigned DEPTH            = DEPTH_DEFAULT,
  parameter int unsigned LOAD_READY_STAGE = LOAD_READY_STAGE_DEFAULT,
  parameter int unsigned SEL_W            = $clog2(DEPTH + 1)
) (
  input  fwd_entry_t [DEPTH-1:0]  entries_i,
  input  logic [REG_AW-1:0]       src_i,
  output logic [SEL_W-1:0]        sel_o,
  output logic                    not_ready_o
);

  logic             found;
  logic             win_load;
  logic [SEL_W-1:0] win_idx;

  // Youngest matching entry wins; array slot k holds entry index k+1.
  always_comb begin
    found       = 1'b0;
    win_load    = 1'b0;
    win_idx     = SEL_W'(FWD_NONE);
    not_ready_o = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!found && entries_i[k].valid && entries_i[k].regwrite &&
          (entries_i[k].rd != '0) && (entries_i[k].rd == src_i)) begin
        found    = 1'b1;
        win_load = entries_i[k].is_load;
        win_idx  = SEL_W'(k + 1);
        // Load data only appears from LOAD_READY_STAGE onwards
        not_ready_o = entries_i[k].is_load && ((k + 1) < int'(LOAD_READY_STAGE));
      end
    end
    sel_o = not_ready_o ? SEL_W'(FWD_NONE) : win_idx;
  end

endmodule

// File: rtl/forwarding_scoreboard.sv
// Forwarding scoreboard: tracks destination tags of post-EX instructions,
// drives per-source forward selects and detects load-use hazards.
module forwarding_scoreboard
  import forwarding_pkg::*;
#(
  parameter int unsigned NUM_SRC          = NUM_SRC_DEFAULT,
  parameter int unsigned DEPTH            = DEPTH_DEFAULT,
  parameter int unsigned LOAD_READY_STAGE = LOAD_READY_STAGE_DEFAULT,
  localparam int unsigned SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       advance_i,
  input  logic                       flush_i,
  input  logic                       ex_valid_i,
  input  logic                       ex_regwrite_i,
  input  logic                       ex_is_load_i,
  input  logic [REG_AW-1:0]          ex_rd_i,
  input  logic [NUM_SRC*REG_AW-1:0]  ex_src_i,
  output logic [NUM_SRC*SEL_W-1:0]   fwd_sel_o,
  output logic                       stall_o,
  output logic [15:0]                stall_cnt_o
);

  fwd_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [15:0]            stall_cnt_q, stall_cnt_d;
  logic [NUM_SRC-1:0]     not_ready;

  for (genvar s = 0; s < int'(NUM_SRC); s++) begin : g_match
    fwd_match #(
      .DEPTH            (DEPTH),
      .LOAD_READY_STAGE (LOAD_READY_STAGE),
      .SEL_W            (SEL_W)
    ) u_match (
      .entries_i   (entries_q),
      .src_i       (ex_src_i[REG_AW*s +: REG_AW]),
      .sel_o       (fwd_sel_o[SEL_W*s +: SEL_W]),
      .not_ready_o (not_ready[s])
    );
  end

  // Hazard only matters when EX holds a real instruction
  assign stall_o     = ex_valid_i && (|not_ready);
  assign stall_cnt_o = stall_cnt_q;

  // Next-state: shift the tag pipe on advance, insert EX tag or a bubble
  always_comb begin
    entries_d   = entries_q;
    stall_cnt_d = stall_cnt_q;
    if (advance_i) begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = '0;
      if (ex_valid_i && !stall_o && !flush_i) begin
        entries_d[0].valid    = 1'b1;
        entries_d[0].regwrite = ex_regwrite_i;
        entries_d[0].is_load  = ex_is_load_i;
        entries_d[0].rd       = ex_rd_i;
      end
      // A flushed stall cycle still counts as a stall cycle
      if (stall_o && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_d = stall_cnt_q + 16'd1;
      end
    end
  end

  // State registers with synchronous reset taking priority over everything
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entries_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard (defaults: 2 sources, depth 3,
// loads ready at entry 2). Stimulus pushes expectations; monitor checks them.
module tb_forwarding_scoreboard;

  localparam int SEL_W = 2;

  logic        clk = 1'b0;
  logic        rst, advance, flush, ex_valid, ex_regwrite, ex_is_load;
  logic [4:0]  ex_rd;
  logic [9:0]  ex_src;
  logic [3:0]  fwd_sel;
  logic        stall;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          kind;  // 0 sel0, 1 sel1, 2 stall, 3 stall count
    int unsigned val;
  } exp_t;

  exp_t exp_q[$];

  forwarding_scoreboard dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .advance_i     (advance),
    .flush_i       (flush),
    .ex_valid_i    (ex_valid),
    .ex_regwrite_i (ex_regwrite),
    .ex_is_load_i  (ex_is_load),
    .ex_rd_i       (ex_rd),
    .ex_src_i      (ex_src),
    .fwd_sel_o     (fwd_sel),
    .stall_o       (stall),
    .stall_cnt_o   (stall_cnt)
  );

  always #5 clk = ~clk;

  // Monitor: outputs are stable mid-cycle, compare every pending expectation
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      int unsigned got;
      e = exp_q.pop_front();
      case (e.kind)
        0:       got = int'(fwd_sel[SEL_W-1:0]);
        1:       got = int'(fwd_sel[2*SEL_W-1:SEL_W]);
        2:       got = int'(stall);
        default: got = int'(stall_cnt);
      endcase
      checks++;
      if (got != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, got, e.val);
      end
    end
  end

  task automatic drive(input logic v, input logic rw, input logic ld, input logic [4:0] rd,
                       input logic [4:0] s0, input logic [4:0] s1,
                       input logic adv, input logic fl, input logic rs);
    ex_valid    = v;
    ex_regwrite = rw;
    ex_is_load  = ld;
    ex_rd       = rd;
    ex_src      = {s1, s0};
    advance     = adv;
    flush       = fl;
    rst         = rs;
  endtask

  task automatic expect_val(input string n, input int k, input int unsigned v);
    exp_t e;
    e.name = n;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    step();
    step();

    // Reset state
    drive(0, 0, 0, 0, 3, 3, 0, 0, 0);
    expect_val("reset_sel0", 0, 0);
    expect_val("reset_sel1", 1, 0);
    expect_val("reset_stall", 2, 0);
    expect_val("reset_cnt", 3, 0);
    step();

    // ALU chaining on r3
    drive(1, 1, 0, 3, 0, 0, 1, 0, 0);
    expect_val("alu_issue_stall", 2, 0);
    step();
    drive(1, 0, 0, 0, 3, 0, 1, 0, 0);
    expect_val("alu_sel0_e1", 0, 1);
    expect_val("alu_stall", 2, 0);
    step();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
    expect_val("alu_sel1_e2", 1, 2);
    step();
    drive(0, 0, 0, 0, 0, 3, 1, 0, 0);
    expect_val("alu_sel1_e3", 1, 3);
    step();
    drive(0, 0, 0, 0, 3, 3, 0, 0, 0);
    expect_val("alu_gone_sel0", 0, 0);
    expect_val("alu_gone_sel1", 1, 0);
    step();

    // Double hazard on r5: youngest wins
    drive(1, 1, 0, 5, 0, 0, 1, 0, 0);
    step();
    drive(1, 1, 0, 5, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 5, 0, 0, 0, 0);
    expect_val("double_sel0", 0, 1);
    expect_val("double_stall", 2, 0);
    step();

    // r0 destination and non-writing tag never forward
    drive(1, 1, 0, 0, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 4, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 0, 4, 0, 0, 0);
    expect_val("r0_sel0", 0, 0);
    expect_val("nowrite_sel1", 1, 0);
    step();
    drive(1, 0, 0, 0, 5, 4, 0, 0, 0);
    expect_val("r5_e3_sel0", 0, 3);
    expect_val("nowrite_sel1_b", 1, 0);
    step();

    // Load-use on r7: one stall cycle, then forward from entry 2
    drive(1, 1, 1, 7, 0, 0, 1, 0, 0);
    expect_val("load_issue_stall", 2, 0);
    step();
    drive(1, 0, 0, 0, 7, 0, 1, 0, 0);
    expect_val("lu_stall", 2, 1);
    expect_val("lu_sel0_blocked", 0, 0);
    expect_val("lu_cnt_before", 3, 0);
    step();
    drive(1, 0, 0, 0, 7, 0, 1, 0, 0);
    expect_val("lu_stall_clear", 2, 0);
    expect_val("lu_sel0_e2", 0, 2);
    expect_val("lu_cnt", 3, 1);
    step();

    // Flush during a stall: bubble inserted, stall still counted
    drive(1, 1, 1, 9, 0, 0, 1, 0, 0);
    step();
    drive(1, 1, 0, 10, 0, 9, 1, 1, 0);
    expect_val("flush_stall", 2, 1);
    expect_val("flush_cnt_before", 3, 1);
    step();
    drive(1, 0, 0, 0, 10, 9, 0, 0, 0);
    expect_val("flush_sel1_e2", 1, 2);
    expect_val("flush_no_insert", 0, 0);
    expect_val("flush_cnt", 3, 2);
    expect_val("flush_stall_clear", 2, 0);
    step();

    // Plain flush of a writing instruction leaves no tag behind
    drive(1, 1, 0, 11, 0, 0, 1, 1, 0);
    step();
    drive(1, 0, 0, 0, 11, 0, 0, 0, 0);
    expect_val("flush_only_sel0", 0, 0);
    step();

    // Reset arriving mid-stall
    drive(1, 1, 1, 12, 0, 0, 1, 0, 0);
    step();
    drive(1, 0, 0, 0, 12, 0, 1, 0, 1);
    expect_val("rst_mid_stall", 2, 1);
    expect_val("rst_mid_cnt", 3, 2);
    step();
    drive(1, 0, 0, 0, 12, 9, 0, 0, 0);
    expect_val("rst_after_stall", 2, 0);
    expect_val("rst_after_sel0", 0, 0);
    expect_val("rst_after_sel1", 1, 0);
    expect_val("rst_after_cnt", 3, 0);
    step();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) step();
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/forwarding_scoreboard.md
FORWARDING_SCOREBOARD -- requirements
Module: forwarding_scoreboard

Interface
REQ-001 SHALL have parameter NUM_SRC, default 2: number of EX-stage source operands checked.
REQ-002 SHALL have parameter DEPTH, default 3: number of in-flight post-EX stages tracked (entry 1 = EX/MEM, entry DEPTH = oldest before write-back completes), legal range 1..7.
REQ-003 SHALL have parameter LOAD_READY_STAGE, default 2: first entry index at which load data is forwardable, legal range 1..DEPTH.
REQ-004 SHALL define SEL_W = clog2(DEPTH+1).
REQ-005 SHALL have port clk_i, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port advance_i, input, 1: pipeline advances this cycle.
REQ-008 SHALL have port flush_i, input, 1: kill the EX instruction.
REQ-009 SHALL have port ex_valid_i, input, 1: the EX slot holds a real instruction.
REQ-010 SHALL have port ex_regwrite_i, input, 1: the EX instruction writes a register.
REQ-011 SHALL have port ex_is_load_i, input, 1: the EX instruction is a load.
REQ-012 SHALL have port ex_rd_i, input, 5: EX destination register.
REQ-013 SHALL have port ex_src_i, input, NUM_SRC*5: packed EX source registers, src k at bits [5k+4:5k].
REQ-014 SHALL have port fwd_sel_o, output, NUM_SRC*SEL_W: per source, 0 = register file, k = forward from entry k.
REQ-015 SHALL have port stall_o, output, 1: load-use hazard; hold the EX instruction.
REQ-016 SHALL have port stall_cnt_o, output, 16: saturating count of stall cycles.

Function
REQ-017 SHALL hold per entry the fields valid, regwrite, is_load and rd[4:0].
REQ-018 SHALL treat an entry as matching source s when it is valid, has regwrite=1, has rd!=0 and has rd==src s.
REQ-019 SHALL set fwd_sel for source s to the smallest matching entry index (youngest wins), or 0 when no entry matches; this output is combinational from the entries and ex_src_i.
REQ-020 SHALL assert stall_o combinationally when ex_valid_i=1 and, for any source, the winning entry has is_load=1 and index < LOAD_READY_STAGE.
REQ-021 SHALL force fwd_sel to 0 for a source whose winning entry is not ready.
REQ-022 SHALL, when advance_i=1, shift entry k into entry k+1 for k = 1..DEPTH-1 and drop entry DEPTH.
REQ-023 SHALL, when advance_i=1, load entry 1 with the EX tag when ex_valid_i=1, stall_o=0 and flush_i=0, and otherwise with a bubble (valid=0).
REQ-024 SHALL leave all entries and stall_cnt_o unchanged when advance_i=0; stall_o and fwd_sel remain combinational.
REQ-025 SHALL increment stall_cnt_o on each cycle with advance_i=1 and stall_o=1, saturating at 16'hFFFF.
REQ-026 SHALL give flush_i priority over stall_o (bubble in either case), while stall_cnt_o still counts that cycle.
REQ-027 SHALL, when DEPTH=2 and LOAD_READY_STAGE=1, produce fwd_sel equal to the classic two-stage EX/MEM-over-MEM/WB priority forwarding.

Reset
REQ-028 SHALL, on rst_i=1 at a clock edge, clear every entry's valid bit and clear stall_cnt_o, so that fwd_sel_o=0 and stall_o=0 from the next cycle.
REQ-029 SHALL give rst_i priority over advance_i and flush_i, including when reset arrives mid-stall.

Structure
REQ-030 SHALL place REG_AW=5, the entry struct typedef, the parameter defaults and the FWD_NONE=0 constant in the shared package forwarding_pkg.
REQ-031 SHALL use one sub-module, fwd_match (per-source priority matcher plus ready check), instantiated NUM_SRC times.

Verification
REQ-032 SHALL verify reset (defaults, DEPTH=3): hold rst_i 2 cycles -> fwd_sel_o=0, stall_o=0, stall_cnt_o=0.
REQ-033 SHALL verify ALU chaining: issue a regwrite to r3 -> next cycle src0=r3 gives sel0=1; one cycle later src1=r3 gives sel1=2; after 3 advances it gives 0.
REQ-034 SHALL verify the double hazard: r5 written in entries 1 and 2, src0=r5 -> sel0=1.
REQ-035 SHALL verify r0 and no-write cases: a tag with rd=0 and regwrite=1, or rd=4 and regwrite=0, with src=0 or 4 -> sel=0.
REQ-036 SHALL verify load-use: a load to r7 followed by src0=r7 -> stall_o=1 for 1 cycle, a bubble enters entry 1, then sel0=2 and stall_cnt_o=1.
REQ-037 SHALL verify flush and reset interplay: flush_i during a stall -> bubble inserted and stall_cnt_o still increments; rst_i asserted mid-stall -> all outputs 0 on the next cycle.
